// File: rtl/mram_access_ctrl.sv
// Access controller for a 16-bit asynchronous MRAM shared by two requesters.
// Round-robin arbitration; setup/pulse/hold strobe sequencing; all outputs registered.
module mram_access_ctrl #(
  parameter int ADDR_W    = 16,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic                SIM_CLK,
  input  logic                SIM_RST,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [31:0]         req_wdata,
  input  logic [3:0]          req_be,
  output logic [1:0]          req_grant,
  output logic [1:0]          rsp_valid,
  output logic [15:0]         rsp_rdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_E_n,
  output logic                mem_G_n,
  output logic                mem_W_n,
  output logic                mem_LB_n,
  output logic                mem_UB_n,
  output logic [15:0]         mem_dq_out,
  output logic                mem_dq_oe,
  input  logic [15:0]         mem_dq_in
);

  localparam int MAX_CYC = (SETUP_CYC > PULSE_CYC) ?
                           ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                           ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, DONE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                last_gnt;   // 1 = requester 1 was granted most recently
  logic                lat_sel;
  logic                lat_write;
  logic [ADDR_W-1:0]   lat_addr;
  logic [15:0]         lat_wdata;
  logic [1:0]          lat_be;
  logic [15:0]         rd_buf;
  logic                pick;

  // With both requesting, the one not served last wins; otherwise the lone requester.
  always_comb begin
    pick = req_valid[1];
    if (req_valid == 2'b11) pick = ~last_gnt;
  end

  // Each state's registered outputs appear in the cycle after the edge that
  // processes that state, so a state spanning N edges shows N cycles of strobes.
  always_ff @(posedge SIM_CLK) begin
    // NOTE: every register here, including the latched request fields, is cleared
    // by the synchronous reset and updated with non-blocking assignments only.
    if (!SIM_RST) begin
      state      <= IDLE;
      cnt        <= '0;
      last_gnt   <= 1'b1;
      lat_sel    <= 1'b0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
      rd_buf     <= '0;
      req_grant  <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      mem_addr   <= '0;
      mem_E_n    <= 1'b1;
      mem_G_n    <= 1'b1;
      mem_W_n    <= 1'b1;
      mem_LB_n   <= 1'b1;
      mem_UB_n   <= 1'b1;
      mem_dq_out <= '0;
      mem_dq_oe  <= 1'b0;
    end else begin
      req_grant <= '0;
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            req_grant <= pick ? 2'b10 : 2'b01;
            last_gnt  <= pick;
            lat_sel   <= pick;
            lat_write <= req_write[pick];
            lat_addr  <= pick ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
            lat_wdata <= pick ? req_wdata[31:16] : req_wdata[15:0];
            lat_be    <= pick ? req_be[3:2] : req_be[1:0];
            cnt       <= CNT_W'(SETUP_CYC);
            state     <= SETUP;
          end
        end
        SETUP: begin
          mem_E_n  <= 1'b0;
          mem_G_n  <= 1'b1;
          mem_W_n  <= 1'b1;
          mem_addr <= lat_addr;
          if (lat_write) begin
            mem_dq_oe  <= 1'b1;
            mem_dq_out <= lat_wdata;
            mem_LB_n   <= ~lat_be[0];
            mem_UB_n   <= ~lat_be[1];
          end else begin
            mem_dq_oe <= 1'b0;
            mem_LB_n  <= 1'b0;
            mem_UB_n  <= 1'b0;
          end
          if (cnt == CNT_W'(1)) begin
            cnt   <= CNT_W'(PULSE_CYC);
            state <= PULSE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PULSE: begin
          if (lat_write) mem_W_n <= 1'b0;
          else           mem_G_n <= 1'b0;
          if (cnt == CNT_W'(1)) begin
            cnt   <= CNT_W'(HOLD_CYC);
            state <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          mem_G_n <= 1'b1;
          mem_W_n <= 1'b1;
          // First HOLD edge closes the final G_n-low cycle: read data is settled here.
          if (cnt == CNT_W'(HOLD_CYC) && !lat_write) rd_buf <= mem_dq_in;
          if (cnt == CNT_W'(1)) state <= DONE;
          else                  cnt   <= cnt - 1'b1;
        end
        DONE: begin
          mem_E_n   <= 1'b1;
          mem_LB_n  <= 1'b1;
          mem_UB_n  <= 1'b1;
          mem_dq_oe <= 1'b0;
          rsp_valid <= lat_sel ? 2'b10 : 2'b01;
          rsp_rdata <= lat_write ? 16'h0000 : rd_buf;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mram_access_ctrl.sv
// Directed bench for mram_access_ctrl: default-timing instance plus a S=2/P=3/H=2 instance,
// both backed by a small byte-strobed memory model.
module tb_mram_access_ctrl;

  logic        SIM_CLK = 1'b0;
  logic        SIM_RST;
  logic [1:0]  req_valid, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic [1:0]  req_grant, rsp_valid;
  logic [15:0] rsp_rdata, mem_addr, mem_dq_out, mem_dq_in;
  logic        mem_E_n, mem_G_n, mem_W_n, mem_LB_n, mem_UB_n, mem_dq_oe;

  logic [1:0]  v5_valid, v5_write, v5_grant, v5_rsp;
  logic [31:0] v5_addr, v5_wdata;
  logic [3:0]  v5_be;
  logic [15:0] v5_rdata, v5_mem_addr, v5_dq_out, v5_dq_in;
  logic        v5_E_n, v5_G_n, v5_W_n, v5_LB_n, v5_UB_n, v5_dq_oe;

  logic [15:0] model_mem [256];
  logic        model_clr;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 SIM_CLK = ~SIM_CLK;

  mram_access_ctrl u_dut (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be), .req_grant(req_grant),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .mem_addr(mem_addr),
    .mem_E_n(mem_E_n), .mem_G_n(mem_G_n), .mem_W_n(mem_W_n),
    .mem_LB_n(mem_LB_n), .mem_UB_n(mem_UB_n), .mem_dq_out(mem_dq_out),
    .mem_dq_oe(mem_dq_oe), .mem_dq_in(mem_dq_in)
  );

  mram_access_ctrl #(.SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2)) u_dut5 (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST),
    .req_valid(v5_valid), .req_write(v5_write), .req_addr(v5_addr),
    .req_wdata(v5_wdata), .req_be(v5_be), .req_grant(v5_grant),
    .rsp_valid(v5_rsp), .rsp_rdata(v5_rdata), .mem_addr(v5_mem_addr),
    .mem_E_n(v5_E_n), .mem_G_n(v5_G_n), .mem_W_n(v5_W_n),
    .mem_LB_n(v5_LB_n), .mem_UB_n(v5_UB_n), .mem_dq_out(v5_dq_out),
    .mem_dq_oe(v5_dq_oe), .mem_dq_in(v5_dq_in)
  );

  // Device model: byte-masked write on each clock with E_n and W_n low; read is combinational.
  always @(posedge SIM_CLK) begin
    if (model_clr) begin
      for (int i = 0; i < 256; i++) model_mem[i] <= 16'h0000;
    end else if (!mem_E_n && !mem_W_n) begin
      if (!mem_LB_n) model_mem[mem_addr[7:0]][7:0]  <= mem_dq_out[7:0];
      if (!mem_UB_n) model_mem[mem_addr[7:0]][15:8] <= mem_dq_out[15:8];
    end
  end

  assign mem_dq_in = (!mem_E_n && !mem_G_n) ? model_mem[mem_addr[7:0]] : 16'h0000;
  assign v5_dq_in  = (!v5_E_n && !v5_G_n) ? model_mem[v5_mem_addr[7:0]] : 16'h0000;

  // Bus-contention invariants, checked on every cycle outside reset.
  always @(negedge SIM_CLK) begin
    if (SIM_RST === 1'b1) begin
      assert (!(!mem_G_n && !mem_W_n) && !(!mem_G_n && mem_dq_oe) && !(mem_dq_oe && mem_E_n))
        else begin
          miscompares++;
          $error("FAIL inv_dut: G_n=%b W_n=%b E_n=%b dq_oe=%b", mem_G_n, mem_W_n, mem_E_n, mem_dq_oe);
        end
      assert (!(!v5_G_n && !v5_W_n) && !(!v5_G_n && v5_dq_oe))
        else begin
          miscompares++;
          $error("FAIL inv_dut5: G_n=%b W_n=%b dq_oe=%b", v5_G_n, v5_W_n, v5_dq_oe);
        end
    end
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
      else begin
        miscompares++;
        $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, observed, expected);
      end
  endtask

  function automatic logic [9:0] bundle();
    return {req_grant, rsp_valid, mem_E_n, mem_G_n, mem_W_n, mem_LB_n, mem_UB_n, mem_dq_oe};
  endfunction

  // Expected {grant, rsp, E_n, G_n, W_n, LB_n, UB_n, dq_oe} for cycle c (1..5) at default timing.
  function automatic logic [9:0] exp_trace(input int c, input logic wr, input logic [1:0] be,
                                           input int r);
    logic lb, ub;
    lb = wr ? ~be[0] : 1'b0;
    ub = wr ? ~be[1] : 1'b0;
    case (c)
      1, 4:    return {4'b0000, 1'b0, 1'b1, 1'b1, lb, ub, wr};
      2, 3:    return {4'b0000, 1'b0, wr, ~wr, lb, ub, wr};
      default: return {2'b00, (r == 1) ? 2'b10 : 2'b01, 6'b111110};
    endcase
  endfunction

  // One complete access from requester r, starting with the DUT idle; checks every cycle.
  task automatic run_access(input int r, input logic wr, input logic [15:0] addr,
                            input logic [15:0] wd, input logic [1:0] be,
                            input logic [15:0] exp_rd, input string tag);
    req_write[r]        = wr;
    req_addr[r*16 +: 16] = addr;
    req_wdata[r*16 +: 16] = wd;
    req_be[r*2 +: 2]    = be;
    req_valid[r]        = 1'b1;
    @(negedge SIM_CLK);
    check({tag, "_grant"}, 32'(req_grant), (r == 1) ? 32'h2 : 32'h1);
    req_valid[r] = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge SIM_CLK);
      check($sformatf("%s_c%0d", tag, c), 32'(bundle()), 32'(exp_trace(c, wr, be, r)));
      if (c == 1) begin
        check({tag, "_addr"}, 32'(mem_addr), 32'(addr));
        if (wr) check({tag, "_dq_out"}, 32'(mem_dq_out), 32'(wd));
      end
      if (c == 5) check({tag, "_rdata"}, 32'(rsp_rdata), 32'(exp_rd));
    end
  endtask

  initial begin
    SIM_RST   = 1'b0;
    model_clr = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_be = '0;
    v5_valid  = '0; v5_write  = '0; v5_addr  = '0; v5_wdata  = '0; v5_be  = '0;
    repeat (3) @(negedge SIM_CLK);
    model_clr = 1'b0;
    check("reset_bundle", 32'(bundle()), 32'h03E);
    check("reset_addr_dq", {mem_addr, mem_dq_out}, 32'h0);
    check("reset_rdata", 32'(rsp_rdata), 32'h0);
    SIM_RST = 1'b1;

    // Write then read back at default timing.
    run_access(0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, 16'h0000, "t1_wr");
    run_access(0, 1'b0, 16'h0010, 16'h0000, 2'b11, 16'hBEEF, "t1_rd");

    // Both requesters read continuously from a fresh pointer: grants 0,1,0,1 every 6 cycles.
    SIM_RST = 1'b0;
    @(negedge SIM_CLK);
    SIM_RST   = 1'b1;
    req_write = 2'b00;
    req_addr  = {16'h0020, 16'h0010};
    req_valid = 2'b11;
    for (int c = 0; c < 24; c++) begin
      @(negedge SIM_CLK);
      check($sformatf("t2_grant_c%0d", c), 32'(req_grant),
            (c % 6 == 0) ? (((c / 6) % 2 == 0) ? 32'h1 : 32'h2) : 32'h0);
      check($sformatf("t2_rsp_c%0d", c), 32'(rsp_valid),
            (c % 6 == 5) ? (((c / 6) % 2 == 0) ? 32'h1 : 32'h2) : 32'h0);
      if (c % 6 == 5)
        check($sformatf("t2_rdata_c%0d", c), 32'(rsp_rdata),
              ((c / 6) % 2 == 0) ? 32'hBEEF : 32'h0);
    end
    req_valid = 2'b00;

    // Partial-byte writes, including an all-disabled write, then readback.
    run_access(1, 1'b1, 16'h0030, 16'hFFFF, 2'b11, 16'h0000, "t3_fill");
    run_access(1, 1'b1, 16'h0030, 16'h1234, 2'b01, 16'h0000, "t3_lb");
    check("t3_model", 32'(model_mem[8'h30]), 32'hFF34);
    run_access(0, 1'b1, 16'h0030, 16'h0000, 2'b00, 16'h0000, "t3_be0");
    run_access(1, 1'b0, 16'h0030, 16'h0000, 2'b00, 16'hFF34, "t3_rd");

    // Reset during a write pulse aborts the access and restores the arbitration pointer.
    req_write[0] = 1'b1; req_addr[15:0] = 16'h0040; req_wdata[15:0] = 16'h5A5A;
    req_be[1:0]  = 2'b11; req_valid[0] = 1'b1;
    @(negedge SIM_CLK);
    check("t4_grant", 32'(req_grant), 32'h1);
    req_valid[0] = 1'b0;
    repeat (2) @(negedge SIM_CLK);
    check("t4_pulse", 32'(bundle()), 32'(exp_trace(2, 1'b1, 2'b11, 0)));
    SIM_RST = 1'b0;
    @(negedge SIM_CLK);
    check("t4_abort", 32'(bundle()), 32'h03E);
    SIM_RST = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge SIM_CLK);
      check($sformatf("t4_no_rsp_%0d", c), 32'(rsp_valid), 32'h0);
    end
    req_write = 2'b00;
    req_addr  = {16'h0020, 16'h0010};
    req_valid = 2'b11;
    @(negedge SIM_CLK);
    check("t4_first_grant", 32'(req_grant), 32'h1);
    req_valid = 2'b00;
    repeat (6) @(negedge SIM_CLK);

    // Stretched timing instance: read completes at cycle 8, G_n low for cycles 3..5.
    v5_write = 2'b00;
    v5_addr  = {16'h0000, 16'h0030};
    v5_valid = 2'b01;
    for (int c = 0; c <= 9; c++) begin
      @(negedge SIM_CLK);
      if (c == 0) begin
        check("t5_grant", 32'(v5_grant), 32'h1);
        v5_valid = 2'b00;
      end
      check($sformatf("t5_rsp_c%0d", c), 32'(v5_rsp), (c == 8) ? 32'h1 : 32'h0);
      check($sformatf("t5_g_c%0d", c), 32'(v5_G_n), (c >= 3 && c <= 5) ? 32'h0 : 32'h1);
      if (c == 8) check("t5_rdata", 32'(v5_rdata), 32'hFF34);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
